// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC commutator: sector codes, FSM states,
// hall decoding and the six-step commutation table.
package bldc_pkg;

    localparam logic [2:0] SEC_A = 3'd0;
    localparam logic [2:0] SEC_B = 3'd1;
    localparam logic [2:0] SEC_C = 3'd2;
    localparam logic [2:0] SEC_D = 3'd3;
    localparam logic [2:0] SEC_E = 3'd4;
    localparam logic [2:0] SEC_F = 3'd5;

    localparam logic [2:0] PH_A = 3'b001;
    localparam logic [2:0] PH_B = 3'b010;
    localparam logic [2:0] PH_C = 3'b100;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DEAD  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // Returns {valid, sector}; 000 and 111 are not legal hall codes.
    function automatic logic [3:0] hall_decode(input logic [2:0] hall);
        logic [3:0] r;
        r = 4'b0000;
        case (hall)
            3'b101:  r = {1'b1, SEC_A};
            3'b100:  r = {1'b1, SEC_B};
            3'b110:  r = {1'b1, SEC_C};
            3'b010:  r = {1'b1, SEC_D};
            3'b011:  r = {1'b1, SEC_E};
            3'b001:  r = {1'b1, SEC_F};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Returns {hi[2:0], lo[2:0]}, each one-hot over {C,B,A}.
    function automatic logic [5:0] comm_pattern(input logic [2:0] sec, input logic dir);
        logic [5:0] p;
        p = 6'b0;
        case (sec)
            SEC_A:   p = dir ? {PH_C, PH_B} : {PH_B, PH_C};
            SEC_B:   p = dir ? {PH_A, PH_B} : {PH_B, PH_A};
            SEC_C:   p = dir ? {PH_A, PH_C} : {PH_C, PH_A};
            SEC_D:   p = dir ? {PH_B, PH_C} : {PH_C, PH_B};
            SEC_E:   p = dir ? {PH_B, PH_A} : {PH_A, PH_B};
            SEC_F:   p = dir ? {PH_C, PH_A} : {PH_A, PH_C};
            default: p = 6'b0;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] next_sector(input logic [2:0] sec);
        return (sec == SEC_F) ? SEC_A : sec + 3'd1;
    endfunction

    function automatic logic sector_adjacent(input logic [2:0] a, input logic [2:0] b);
        return (b == next_sector(a)) || (a == next_sector(b));
    endfunction

endpackage

// File: rtl/hall_period_timer.sv
// Measures cycles between valid sector changes and flags a stalled rotor
// when no change arrives within HALL_TIMEOUT cycles.
module hall_period_timer #(
    parameter int HALL_TIMEOUT = 16_000_000,
    parameter int PERIOD_W     = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                change,
    input  logic                suppress,
    output logic [PERIOD_W-1:0] hall_period,
    output logic                period_valid,
    output logic                stalled
);

    localparam int CW = $clog2(HALL_TIMEOUT + 2);

    logic [CW-1:0]       count_q, count_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                stalled_q, stalled_d;

    // The first change after a stall only restarts measurement: its interval is meaningless.
    always_comb begin
        count_d   = count_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        stalled_d = stalled_q;
        if (change) begin
            count_d = '0;
            if (stalled_q) begin
                stalled_d = 1'b0;
            end else if (!suppress) begin
                period_d = PERIOD_W'(count_q + CW'(1));
                valid_d  = 1'b1;
            end
        end else if (count_q == CW'(HALL_TIMEOUT)) begin
            stalled_d = 1'b1;
            period_d  = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    assign hall_period  = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;

endmodule

// File: rtl/bldc_commutator.sv
// Hall-based six-step commutator with dead time, PWM gating and speed supervision.
// Define BLDC_COMMUTATOR_SKIP_DETECT_EN to add the err_count hall-error/skip counter.
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int DEADTIME_CYCLES = 1024,
    parameter int HALL_TIMEOUT    = 16_000_000,
    parameter int PERIOD_W        = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          hall,
    input  logic                dir,
    input  logic                enable,
    input  logic                fault_n,
    input  logic                pwm_in,
    output logic [2:0]          inh,
    output logic [2:0]          inl,
    output logic [2:0]          sector,
    output logic                hall_error,
    output logic [PERIOD_W-1:0] hall_period,
    output logic                period_valid,
`ifdef BLDC_COMMUTATOR_SKIP_DETECT_EN
    output logic [7:0]          err_count,
`endif
    output logic                stalled
);

    localparam logic [15:0] DT_LOAD = 16'(DEADTIME_CYCLES - 1);

    logic       hall_valid;
    logic [2:0] dec_sector;
    logic       sector_change;
    logic       skip;

    logic [2:0]  sector_q, sector_d;
    logic        hall_error_q, hall_error_d;
    state_t      state_q, state_d;
    logic [15:0] dead_q, dead_d;
    logic [5:0]  pend_q, pend_d;
    logic [2:0]  gate_h_q, gate_h_d;
    logic [2:0]  inl_q, inl_d;
    logic [5:0]  target;
    logic        kill;

    assign {hall_valid, dec_sector} = hall_decode(hall);
    assign sector_change = hall_valid && (dec_sector != sector_q);

`ifdef BLDC_COMMUTATOR_SKIP_DETECT_EN
    assign skip = sector_change && !sector_adjacent(sector_q, dec_sector);
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        sector_d     = hall_valid ? dec_sector : sector_q;
        hall_error_d = !hall_valid;
    end

    // pend_q remembers the pattern the dead-time run is protecting, so a late change restarts it.
    always_comb begin
        target   = comm_pattern(sector_q, dir);
        kill     = !enable || !fault_n || hall_error_q;
        state_d  = state_q;
        dead_d   = dead_q;
        pend_d   = pend_q;
        gate_h_d = gate_h_q;
        inl_d    = inl_q;
        if (kill) begin
            state_d  = ST_OFF;
            gate_h_d = '0;
            inl_d    = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_DEAD;
                    dead_d   = DT_LOAD;
                    pend_d   = target;
                    gate_h_d = '0;
                    inl_d    = '0;
                end
                ST_DEAD: begin
                    gate_h_d = '0;
                    inl_d    = '0;
                    if (target != pend_q) begin
                        dead_d = DT_LOAD;
                        pend_d = target;
                    end else if (dead_q == 16'd0) begin
                        state_d           = ST_DRIVE;
                        {gate_h_d, inl_d} = target;
                    end else begin
                        dead_d = dead_q - 16'd1;
                    end
                end
                ST_DRIVE: begin
                    if (target != {gate_h_q, inl_q}) begin
                        state_d  = ST_DEAD;
                        dead_d   = DT_LOAD;
                        pend_d   = target;
                        gate_h_d = '0;
                        inl_d    = '0;
                    end
                end
                default: begin
                    state_d  = ST_OFF;
                    gate_h_d = '0;
                    inl_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sector_q     <= SEC_A;
            hall_error_q <= 1'b0;
            state_q      <= ST_OFF;
            dead_q       <= '0;
            pend_q       <= '0;
            gate_h_q     <= '0;
            inl_q        <= '0;
        end else begin
            sector_q     <= sector_d;
            hall_error_q <= hall_error_d;
            state_q      <= state_d;
            dead_q       <= dead_d;
            pend_q       <= pend_d;
            gate_h_q     <= gate_h_d;
            inl_q        <= inl_d;
        end
    end

`ifdef BLDC_COMMUTATOR_SKIP_DETECT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (((!hall_valid && !hall_error_q) || skip) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    hall_period_timer #(
        .HALL_TIMEOUT (HALL_TIMEOUT),
        .PERIOD_W     (PERIOD_W)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .change       (sector_change),
        .suppress     (skip),
        .hall_period  (hall_period),
        .period_valid (period_valid),
        .stalled      (stalled)
    );

    assign inh        = gate_h_q & {3{pwm_in}};
    assign inl        = inl_q;
    assign sector     = sector_q;
    assign hall_error = hall_error_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed self-checking bench for bldc_commutator (short stall timeout to keep runs brief).
// Build with BLDC_COMMUTATOR_SKIP_DETECT_EN defined to also exercise err_count.
`timescale 1ns/1ps
module tb_bldc_commutator;

    localparam int DT = 1024;
    localparam int TO = 12000;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    hall;
    logic          dir;
    logic          enable;
    logic          fault_n;
    logic          pwm_in;
    logic [2:0]    inh;
    logic [2:0]    inl;
    logic [2:0]    sector;
    logic          hall_error;
    logic [PW-1:0] hall_period;
    logic          period_valid;
    logic          stalled;
`ifdef BLDC_COMMUTATOR_SKIP_DETECT_EN
    logic [7:0]    err_count;
`endif

    int checks = 0;
    int errors = 0;

    always #31 clk = ~clk;

    bldc_commutator #(
        .DEADTIME_CYCLES (DT),
        .HALL_TIMEOUT    (TO),
        .PERIOD_W        (PW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .hall         (hall),
        .dir          (dir),
        .enable       (enable),
        .fault_n      (fault_n),
        .pwm_in       (pwm_in),
        .inh          (inh),
        .inl          (inl),
        .sector       (sector),
        .hall_error   (hall_error),
        .hall_period  (hall_period),
        .period_valid (period_valid),
`ifdef BLDC_COMMUTATOR_SKIP_DETECT_EN
        .err_count    (err_count),
`endif
        .stalled      (stalled)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] h, input logic d, input logic en, input logic f);
        hall    = h;
        dir     = d;
        enable  = en;
        fault_n = f;
    endtask

    // Negedges until any low-side gate turns on (bounded).
    task automatic waitGatesOn(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (inl == 3'b000 && n < 4000);
    endtask

    // Length of the next run of all-off gate cycles (bounded).
    task automatic measureDead(output int zeros);
        zeros = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (inl == 3'b000 && inh == 3'b000) zeros++;
            else if (zeros > 0) break;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) checkOutput("no_overlap", 32'(inh & inl), 32'd0);
    end

    logic [2:0] hall_seq [6] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};

    initial begin
        int n;
        reset_n = 1'b0;
        pwm_in  = 1'b1;
        applyStimulus(3'b101, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_inl", 32'(inl), 32'd0);
        checkOutput("rst_inh", 32'(inh), 32'd0);
        checkOutput("rst_sector", 32'(sector), 32'd0);
        checkOutput("rst_hall_error", 32'(hall_error), 32'd0);
        checkOutput("rst_period", 32'(hall_period), 32'd0);
        checkOutput("rst_valid", 32'(period_valid), 32'd0);
        checkOutput("rst_stalled", 32'(stalled), 32'd1);

        // Start-up in sector A, forward
        reset_n = 1'b1;
        waitGatesOn(n);
        checkOutput("startup_latency", 32'(n), 32'd1025);
        checkOutput("startup_inl", 32'(inl), 32'b010);
        checkOutput("startup_inh", 32'(inh), 32'b100);
        pwm_in = 1'b0;
        #1;
        checkOutput("pwm_off_inh", 32'(inh), 32'd0);
        checkOutput("pwm_off_inl", 32'(inl), 32'b010);
        pwm_in = 1'b1;
        #1;
        checkOutput("pwm_on_inh", 32'(inh), 32'b100);

        // A -> B: exact dead time then hi=A lo=B
        hall = 3'b100;
        measureDead(n);
        checkOutput("dead_len", 32'(n), 32'(DT));
        checkOutput("b_fwd_inl", 32'(inl), 32'b010);
        checkOutput("b_fwd_inh", 32'(inh), 32'b001);

        // Rotation every 5000 cycles
        for (int i = 0; i < 6; i++) begin
            hall = hall_seq[i];
            @(negedge clk);
            checkOutput("rot_sector", 32'(sector), 32'((i + 2) % 6));
            if (i > 0) begin
                checkOutput("rot_valid", 32'(period_valid), 32'd1);
                checkOutput("rot_period", 32'(hall_period), 32'd5000);
            end
            @(negedge clk);
            checkOutput("rot_valid_pulse", 32'(period_valid), 32'd0);
            repeat (4998) @(negedge clk);
        end
        checkOutput("rot_end_inl", 32'(inl), 32'b010);

        // Invalid hall code
        hall = 3'b111;
        @(negedge clk);
        checkOutput("herr_flag", 32'(hall_error), 32'd1);
        checkOutput("herr_sector", 32'(sector), 32'd1);
        @(negedge clk);
        checkOutput("herr_inl", 32'(inl), 32'd0);
        checkOutput("herr_inh", 32'(inh), 32'd0);
        hall = 3'b100;
        waitGatesOn(n);
        checkOutput("herr_recover", 32'(n), 32'd1026);
        checkOutput("herr_rec_inl", 32'(inl), 32'b010);
        checkOutput("herr_rec_hall_error", 32'(hall_error), 32'd0);

        // Direction change, then fault during dead time
        dir = 1'b0;
        @(negedge clk);
        checkOutput("dir_dead_inl", 32'(inl), 32'd0);
        repeat (100) @(negedge clk);
        fault_n = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("fault_inl", 32'(inl), 32'd0);
        fault_n = 1'b1;
        waitGatesOn(n);
        checkOutput("fault_restart", 32'(n), 32'd1025);
        checkOutput("b_rev_inl", 32'(inl), 32'b001);
        checkOutput("b_rev_inh", 32'(inh), 32'b010);

        // Stall detection
        checkOutput("pre_stall", 32'(stalled), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!stalled && n < 8000);
        checkOutput("stall_flag", 32'(stalled), 32'd1);
        checkOutput("stall_period", 32'(hall_period), 32'd0);
        hall = 3'b110;
        @(negedge clk);
        checkOutput("unstall_valid", 32'(period_valid), 32'd0);
        checkOutput("unstall_flag", 32'(stalled), 32'd0);
        checkOutput("unstall_sector", 32'(sector), 32'd2);
        @(negedge clk);
        checkOutput("unstall_valid2", 32'(period_valid), 32'd0);
`ifdef BLDC_COMMUTATOR_SKIP_DETECT_EN
        hall = 3'b101;
        @(negedge clk);
        checkOutput("skip_err_count", 32'(err_count), 32'd2);
        checkOutput("skip_no_strobe", 32'(period_valid), 32'd0);
        checkOutput("skip_sector", 32'(sector), 32'd0);
        waitGatesOn(n);
        checkOutput("pre_reset_inl", 32'(inl), 32'b100);
`else
        waitGatesOn(n);
        checkOutput("pre_reset_inl", 32'(inl), 32'b001);
`endif

        // Asynchronous reset mid-drive, then exact stall timing
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_inl", 32'(inl), 32'd0);
        checkOutput("async_rst_inh", 32'(inh), 32'd0);
        checkOutput("async_rst_stalled", 32'(stalled), 32'd1);
`ifdef BLDC_COMMUTATOR_SKIP_DETECT_EN
        checkOutput("async_rst_err_count", 32'(err_count), 32'd0);
`endif
        hall = 3'b100;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_change_sector", 32'(sector), 32'd1);
        checkOutput("rst_change_stalled", 32'(stalled), 32'd0);
        repeat (TO) @(negedge clk);
        checkOutput("stall_edge_before", 32'(stalled), 32'd0);
        @(negedge clk);
        checkOutput("stall_edge_at", 32'(stalled), 32'd1);
        checkOutput("stall_edge_period", 32'(hall_period), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
